// File: rtl/joystick_splitter_scan.sv
// joystick_splitter_scan
// Time-multiplexed DB9 joystick scanner with per-channel debounce.
// One-hot active-low select lines let several joysticks share one physical
// port. A pass-through mode serves boards with no splitter fitted.
// Line order per joystick, MSB to LSB: {btnN..btn1, right, left, down, up}.

module joystick_splitter_scan #(
  parameter int NJOY     = 2,
  parameter int NBTN     = 2,
  parameter int SETTLE   = 64,
  parameter int DEBOUNCE = 3
) (
  input  logic                       sysclk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       passthru,
  input  logic [NBTN+3:0]            joy_in,
  output logic [NJOY-1:0]            joy_sel_n,
  output logic [NJOY*(NBTN+4)-1:0]   joy_out,
  output logic                       scan_done
);

  localparam int W   = NBTN + 4;
  localparam int CHW = (NJOY > 1) ? $clog2(NJOY) : 1;
  localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CHW-1:0]  CH_LAST  = CHW'(NJOY - 1);
  localparam logic [CW-1:0]   SET_LAST = CW'(SETTLE - 1);
  localparam logic [3:0]      DB_LAST  = 4'(DEBOUNCE - 1);
  localparam logic [NJOY-1:0] SEL_IDLE = {NJOY{1'b1}};
  localparam logic [NJOY-1:0] SEL_ONE  = NJOY'(1);
  localparam logic [NJOY-1:0] SEL_PT   = ~SEL_ONE;

  typedef enum logic [1:0] {
    ST_SELECT  = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_SAMPLE  = 2'd2,
    ST_ADVANCE = 2'd3
  } state_t;

  // Scan sequencer state
  state_t          state_r;
  state_t          state_s;
  logic [CHW-1:0]  ch_r;
  logic [CHW-1:0]  ch_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_s;
  logic [NJOY-1:0] sel_s;
  logic            done_s;
  logic            smp_en_s;
  logic            clr_s;

  // Passthru edge tracking and pass-through input register
  logic            pt_q_r;
  logic [W-1:0]    pt_in_r;

  // Per-channel debounce state
  logic [W-1:0]    last_raw_r [NJOY];
  logic [3:0]      stab_r     [NJOY];

  // Debounce update for the channel being sampled this cycle
  logic [CHW-1:0]  dch_s;
  logic [W-1:0]    din_s;
  logic [3:0]      cur_cnt_s;
  logic [3:0]      db_cnt_s;
  logic            db_upd_s;

  // Next-state, select and sample-strobe decode for the scan FSM
  always_comb begin
    state_s  = state_r;
    ch_s     = ch_r;
    cnt_s    = cnt_r;
    sel_s    = joy_sel_n;
    done_s   = 1'b0;
    smp_en_s = 1'b0;
    clr_s    = 1'b0;
    if (!en) begin
      // Idle: park at channel 0 with every select released
      state_s = ST_SELECT;
      ch_s    = '0;
      cnt_s   = '0;
      sel_s   = SEL_IDLE;
    end else if (passthru != pt_q_r) begin
      // Mode change: restart the scan and forget partial debounce runs
      state_s = ST_SELECT;
      ch_s    = '0;
      cnt_s   = '0;
      sel_s   = passthru ? SEL_PT : SEL_IDLE;
      clr_s   = 1'b1;
    end else if (passthru) begin
      // Direct mode: channel 0 always selected, sampled every cycle
      state_s  = ST_SELECT;
      ch_s     = '0;
      cnt_s    = '0;
      sel_s    = SEL_PT;
      smp_en_s = 1'b1;
    end else begin
      case (state_r)
        ST_SELECT: begin
          sel_s   = SEL_IDLE ^ (SEL_ONE << ch_r);
          cnt_s   = '0;
          state_s = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_r == SET_LAST) begin
            state_s = ST_SAMPLE;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
        ST_SAMPLE: begin
          smp_en_s = 1'b1;
          state_s  = ST_ADVANCE;
        end
        ST_ADVANCE: begin
          if (ch_r == CH_LAST) begin
            ch_s   = '0;
            done_s = 1'b1;
          end else begin
            ch_s = ch_r + CHW'(1);
          end
          state_s = ST_SELECT;
        end
        default: begin
          state_s = ST_SELECT;
          ch_s    = '0;
          cnt_s   = '0;
        end
      endcase
    end
  end

  // Debounce arithmetic for the channel selected by the current mode
  always_comb begin
    if (passthru) begin
      dch_s = '0;
      din_s = pt_in_r;
    end else begin
      dch_s = ch_r;
      din_s = joy_in;
    end
    cur_cnt_s = stab_r[dch_s];
    if (din_s == last_raw_r[dch_s]) begin
      if (cur_cnt_s == DB_LAST) begin
        db_cnt_s = cur_cnt_s;
      end else begin
        db_cnt_s = cur_cnt_s + 4'd1;
      end
    end else begin
      db_cnt_s = 4'd0;
    end
    db_upd_s = (db_cnt_s == DB_LAST);
  end

  // Sequencer registers, select lines and round-complete pulse
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_r   <= ST_SELECT;
      ch_r      <= '0;
      cnt_r     <= '0;
      joy_sel_n <= SEL_IDLE;
      scan_done <= 1'b0;
      pt_q_r    <= 1'b0;
      pt_in_r   <= {W{1'b1}};
    end else begin
      state_r   <= state_s;
      ch_r      <= ch_s;
      cnt_r     <= cnt_s;
      joy_sel_n <= sel_s;
      scan_done <= done_s;
      pt_q_r    <= en ? passthru : pt_q_r;
      pt_in_r   <= joy_in;
    end
  end

  // Per-channel debounce state and debounced outputs
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      joy_out <= {(NJOY*W){1'b1}};
      for (int k = 0; k < NJOY; k++) begin
        last_raw_r[k] <= {W{1'b1}};
        stab_r[k]     <= 4'd0;
      end
    end else begin
      if (clr_s) begin
        for (int k = 0; k < NJOY; k++) begin
          stab_r[k] <= 4'd0;
        end
      end else if (smp_en_s) begin
        last_raw_r[dch_s] <= din_s;
        stab_r[dch_s]     <= db_cnt_s;
        if (db_upd_s) begin
          joy_out[int'(dch_s)*W +: W] <= din_s;
        end
      end
      // Unscanned channels read as released while in direct mode
      if (en && passthru) begin
        for (int k = 1; k < NJOY; k++) begin
          joy_out[k*W +: W] <= {W{1'b1}};
        end
      end
    end
  end

endmodule

// File: tb/tb_joystick_splitter_scan.sv
// Directed bench for joystick_splitter_scan with NJOY=2, NBTN=2, SETTLE=4,
// DEBOUNCE=3 (W=6, one round = 14 cycles). A small splitter model drives
// joy_in from the selected joystick; expected values are hand-derived.

module tb_joystick_splitter_scan;

  logic        sysclk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        passthru;
  logic [5:0]  joy_in;
  logic [1:0]  joy_sel_n;
  logic [11:0] joy_out;
  logic        scan_done;

  // Splitter model state: per-joystick line levels and pass-through level
  logic [5:0]  j0;
  logic [5:0]  j1;
  logic [5:0]  pt_val;
  logic        pt_mode;

  int n_cmp = 0;
  int n_err = 0;

  joystick_splitter_scan #(
    .NJOY(2), .NBTN(2), .SETTLE(4), .DEBOUNCE(3)
  ) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .en        (en),
    .passthru  (passthru),
    .joy_in    (joy_in),
    .joy_sel_n (joy_sel_n),
    .joy_out   (joy_out),
    .scan_done (scan_done)
  );

  // Free-running system clock
  always #5 sysclk = ~sysclk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock edge, then drive joy_in as the splitter would for the current select
  task automatic tick();
    @(posedge sysclk);
    #1;
    if (pt_mode) begin
      joy_in = pt_val;
    end else if (joy_sel_n == 2'b10) begin
      joy_in = j0;
    end else if (joy_sel_n == 2'b01) begin
      joy_in = j1;
    end else begin
      joy_in = 6'h3F;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    passthru = 1'b0;
    joy_in   = 6'h3F;
    j0       = 6'h3F;
    j1       = 6'h3F;
    pt_val   = 6'h3F;
    pt_mode  = 1'b0;

    // Reset and idle
    repeat (3) tick();
    check_eq("rst_sel", 32'(joy_sel_n), 32'h3);
    check_eq("rst_out", 32'(joy_out), 32'hFFF);
    check_eq("rst_done", 32'(scan_done), 32'h0);
    rst_n = 1'b1;
    en    = 1'b1;
    for (int i = 1; i <= 28; i++) begin
      tick();
      check_eq("idle_sel", 32'(joy_sel_n), (((i - 1) % 14) < 7) ? 32'h2 : 32'h1);
      check_eq("idle_done", 32'(scan_done), ((i % 14) == 0) ? 32'h1 : 32'h0);
      check_eq("idle_out", 32'(joy_out), 32'hFFF);
    end

    // Debounce reject: fire1 of joystick 0 toggles every round
    for (int r = 0; r < 6; r++) begin
      j0 = (r % 2 == 0) ? 6'h2F : 6'h3F;
      for (int i = 0; i < 14; i++) begin
        tick();
        check_eq("reject_out", 32'(joy_out), 32'hFFF);
      end
    end

    // Channel separation: up on joystick 0, btn2 on joystick 1
    j0 = 6'h3E;
    j1 = 6'h1F;
    for (int i = 1; i <= 41; i++) begin
      tick();
      check_eq("sep_out", 32'(joy_out),
               (i < 34) ? 32'hFFF : ((i < 41) ? 32'hFFE : 32'h7FE));
    end
    tick();
    check_eq("sep_done", 32'(scan_done), 32'h1);

    // Enable drop in the middle of channel 1 settle
    repeat (9) tick();
    check_eq("abort_presel", 32'(joy_sel_n), 32'h1);
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("abort_sel", 32'(joy_sel_n), 32'h3);
      check_eq("abort_done", 32'(scan_done), 32'h0);
      check_eq("abort_out", 32'(joy_out), 32'h7FE);
    end
    en = 1'b1;
    tick();
    check_eq("reen_sel0", 32'(joy_sel_n), 32'h2);
    repeat (6) tick();
    check_eq("reen_sel0_end", 32'(joy_sel_n), 32'h2);
    tick();
    check_eq("reen_sel1", 32'(joy_sel_n), 32'h1);
    repeat (5) tick();
    check_eq("reen_nodone", 32'(scan_done), 32'h0);
    tick();
    check_eq("reen_done", 32'(scan_done), 32'h1);

    // Pass-through mode
    passthru = 1'b1;
    pt_mode  = 1'b1;
    pt_val   = 6'h3F;
    joy_in   = 6'h3F;
    tick();
    check_eq("pt_enter_out", 32'(joy_out), 32'hFFE);
    for (int i = 2; i <= 7; i++) begin
      tick();
      check_eq("pt_sel", 32'(joy_sel_n), 32'h2);
      check_eq("pt_done", 32'(scan_done), 32'h0);
      check_eq("pt_ch1", 32'(joy_out[11:6]), 32'h3F);
    end
    check_eq("pt_settled", 32'(joy_out), 32'hFFF);
    pt_val = 6'h3B;
    joy_in = 6'h3B;
    repeat (3) tick();
    check_eq("pt_early", 32'(joy_out), 32'hFFF);
    tick();
    check_eq("pt_step", 32'(joy_out), 32'hFFB);
    check_eq("pt_step_sel", 32'(joy_sel_n), 32'h2);
    check_eq("pt_step_done", 32'(scan_done), 32'h0);

    // Leave pass-through, then reset during channel 1 sample
    passthru = 1'b0;
    pt_mode  = 1'b0;
    joy_in   = j0;
    tick();
    repeat (12) tick();
    check_eq("mid_sel", 32'(joy_sel_n), 32'h1);
    check_eq("mid_out", 32'(joy_out), 32'hFFB);
    rst_n = 1'b0;
    tick();
    check_eq("mrst_sel", 32'(joy_sel_n), 32'h3);
    check_eq("mrst_out", 32'(joy_out), 32'hFFF);
    check_eq("mrst_done", 32'(scan_done), 32'h0);
    rst_n = 1'b1;
    tick();
    check_eq("post_done", 32'(scan_done), 32'h0);
    check_eq("post_sel", 32'(joy_sel_n), 32'h2);
    check_eq("post_out", 32'(joy_out), 32'hFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
